// File: rtl/tron_pkg.sv
// Shared Tron definitions: heading encodings, pushbutton bit indices and the
// per-channel debounce state type. Also used by the game pixel/logic block.
package tron_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_LEFT  = 2'b01,
      DIR_UP    = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_t;

   localparam int BTN_C   = 0;
   localparam int BTN_U   = 1;
   localparam int BTN_D   = 2;
   localparam int BTN_L   = 3;
   localparam int BTN_R   = 4;
   localparam int NUM_BTN = 5;

   typedef enum logic [1:0] {
      LOW_STABLE,
      LOW_WAIT,
      HIGH_STABLE,
      HIGH_WAIT
   } deb_state_t;

   // Opposite headings share the axis bit and differ only in the sense bit.
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton channel: 2-flop synchronizer followed by a four-state
// debounce FSM that registers the accepted level and a rising-edge pulse.
module btn_debounce
   import tron_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic pulse
);

   // The STABLE->WAIT transition already consumes the first differing sample
   // with the counter at 0, so the last sample arrives when it reads N-2.
   localparam logic [CNT_W-1:0] LAST =
      (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;

   logic             sync1;
   logic             sync2;
   deb_state_t       state;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= LOW_STABLE;
         count <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         pulse <= 1'b0;
         case (state)
            LOW_STABLE: begin
               count <= '0;
               if (sync2) begin
                  if (DEBOUNCE_CYCLES <= 1) begin
                     state <= HIGH_STABLE;
                     level <= 1'b1;
                     pulse <= 1'b1;
                  end else begin
                     state <= LOW_WAIT;
                  end
               end
            end
            LOW_WAIT: begin
               if (!sync2) begin
                  state <= LOW_STABLE;
                  count <= '0;
               end else if (count == LAST) begin
                  state <= HIGH_STABLE;
                  count <= '0;
                  level <= 1'b1;
                  pulse <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            HIGH_STABLE: begin
               count <= '0;
               if (!sync2) begin
                  if (DEBOUNCE_CYCLES <= 1) begin
                     state <= LOW_STABLE;
                     level <= 1'b0;
                  end else begin
                     state <= HIGH_WAIT;
                  end
               end
            end
            HIGH_WAIT: begin
               if (sync2) begin
                  state <= HIGH_STABLE;
                  count <= '0;
               end else if (count == LAST) begin
                  state <= LOW_STABLE;
                  count <= '0;
                  level <= 1'b0;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               state <= LOW_STABLE;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tron_btn_conditioner.sv
// Debounces the five Tron pushbuttons and turns their rising edges into a
// heading (with reverse-move rejection) and a game reset strobe.
module tron_btn_conditioner
   import tron_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] btn_raw,
   output logic [4:0] btn_level,
   output logic [4:0] btn_pulse,
   output logic [1:0] dir_out,
   output logic       dir_valid,
   output logic       game_reset
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clk  (clk),
         .reset(reset),
         .raw  (btn_raw[i]),
         .level(btn_level[i]),
         .pulse(btn_pulse[i])
      );
   end

   dir_t dir_q;
   dir_t cand;
   logic cand_vld;

   // At most one direction candidate per cycle, U > D > L > R.
   always_comb begin
      cand     = DIR_RIGHT;
      cand_vld = 1'b0;
      if (btn_pulse[BTN_U]) begin
         cand     = DIR_UP;
         cand_vld = 1'b1;
      end else if (btn_pulse[BTN_D]) begin
         cand     = DIR_DOWN;
         cand_vld = 1'b1;
      end else if (btn_pulse[BTN_L]) begin
         cand     = DIR_LEFT;
         cand_vld = 1'b1;
      end else if (btn_pulse[BTN_R]) begin
         cand     = DIR_RIGHT;
         cand_vld = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dir_q      <= DIR_RIGHT;
         dir_valid  <= 1'b0;
         game_reset <= 1'b0;
      end else begin
         dir_valid  <= 1'b0;
         game_reset <= 1'b0;
         if (btn_pulse[BTN_C]) begin
            dir_q      <= DIR_RIGHT;
            dir_valid  <= 1'b1;
            game_reset <= 1'b1;
         end else if (cand_vld && !is_reverse(cand, dir_q)) begin
            dir_q     <= cand;
            dir_valid <= 1'b1;
         end
      end
   end

   assign dir_out = dir_q;

endmodule

// File: tb/tb_tron_btn_conditioner.sv
// Scoreboard bench for tron_btn_conditioner with DEBOUNCE_CYCLES=4.
module tb_tron_btn_conditioner;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] btn_raw;
   logic [4:0] btn_level;
   logic [4:0] btn_pulse;
   logic [1:0] dir_out;
   logic       dir_valid;
   logic       game_reset;

   tron_btn_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse),
      .dir_out   (dir_out),
      .dir_valid (dir_valid),
      .game_reset(game_reset)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [4:0] pulse;
      logic [4:0] level;
      logic       dv;
      logic [1:0] dir;
      logic       gr;
   } evt_t;

   evt_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [1:0] exp_dir = 2'b00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [4:0] p, input logic [4:0] l,
                       input logic dv, input logic [1:0] d, input logic gr);
      evt_t e;
      e.cyc = c; e.pulse = p; e.level = l; e.dv = dv; e.dir = d; e.gr = gr;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press, hold past acceptance, release; dv/new_dir/gr describe the strobe
   // expected the cycle after the debounced pulse (dv=0: none expected).
   task automatic press_release(input logic [4:0] v, input logic dv,
                                input logic [1:0] new_dir, input logic gr);
      int e;
      e = cyc;
      btn_raw = v;
      push(e + 6, v, v, 1'b0, exp_dir, 1'b0);
      if (dv) begin
         push(e + 7, 5'b0, v, 1'b1, new_dir, gr);
         exp_dir = new_dir;
      end
      step(10);
      btn_raw = 5'b0;
      step(8);
   endtask

   // Monitor: every cycle the DUT presents a strobe, pop and compare.
   always @(negedge clk) begin
      if (!reset && (btn_pulse != 5'b0 || dir_valid || game_reset)) begin
         if (sb.size() == 0) begin
            chk("unexpected_evt", {btn_pulse, dir_valid, dir_out, game_reset}, 32'h0);
         end else begin
            evt_t e;
            e = sb.pop_front();
            chk("evt_cycle", cyc, e.cyc);
            chk("evt_pulse", btn_pulse, e.pulse);
            chk("evt_level", btn_level, e.level);
            chk("evt_dir_valid", dir_valid, e.dv);
            chk("evt_dir_out", dir_out, e.dir);
            chk("evt_game_reset", game_reset, e.gr);
         end
      end
   end

   initial begin
      int e;
      reset   = 1'b1;
      btn_raw = 5'b0;
      step(3);
      reset = 1'b0;
      step(1);
      chk("rst_level", btn_level, 5'b0);
      chk("rst_pulse", btn_pulse, 5'b0);
      chk("rst_dir", dir_out, 2'b00);
      chk("rst_dir_valid", dir_valid, 1'b0);
      chk("rst_game_reset", game_reset, 1'b0);

      // U held: level rises 6 cycles later, heading becomes up one cycle after
      press_release(5'b00010, 1'b1, 2'b10, 1'b0);
      chk("u_released_level", btn_level, 5'b0);

      // L glitch of 3 cycles: rejected, counter back to 0
      btn_raw = 5'b01000;
      step(3);
      btn_raw = 5'b0;
      step(8);
      chk("glitch_level", btn_level, 5'b0);
      chk("glitch_count", u_dut.g_btn[3].u_deb.count, 3'd0);

      // L held exactly 4 cycles: just long enough, heading up -> left
      e = cyc;
      btn_raw = 5'b01000;
      push(e + 6, 5'b01000, 5'b01000, 1'b0, exp_dir, 1'b0);
      push(e + 7, 5'b0, 5'b01000, 1'b1, 2'b01, 1'b0);
      exp_dir = 2'b01;
      step(4);
      btn_raw = 5'b0;
      step(14);

      // C: game reset, heading right; then L rejected as reverse; then U
      press_release(5'b00001, 1'b1, 2'b00, 1'b1);
      press_release(5'b01000, 1'b0, 2'b00, 1'b0);
      chk("reverse_dir_held", dir_out, 2'b00);
      press_release(5'b00010, 1'b1, 2'b10, 1'b0);

      // U and R together: U wins, single strobe re-asserting up
      press_release(5'b10010, 1'b1, 2'b10, 1'b0);

      // C and D together with heading up: game reset wins
      press_release(5'b00101, 1'b1, 2'b00, 1'b1);

      // Heading up again, then R held with reset pulsed mid-debounce
      press_release(5'b00010, 1'b1, 2'b10, 1'b0);
      e = cyc;
      btn_raw = 5'b10000;
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("midrst_level", btn_level, 5'b0);
      chk("midrst_pulse", btn_pulse, 5'b0);
      chk("midrst_dir", dir_out, 2'b00);
      chk("midrst_dir_valid", dir_valid, 1'b0);
      chk("midrst_game_reset", game_reset, 1'b0);
      exp_dir = 2'b00;
      push(e + 9, 5'b10000, 5'b10000, 1'b0, 2'b00, 1'b0);
      push(e + 10, 5'b0, 5'b10000, 1'b1, 2'b00, 1'b0);
      step(10);
      btn_raw = 5'b0;
      step(8);

      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached at cycle %0d expected finish earlier", cyc);
      $fatal(1, "timeout");
   end

endmodule
